// File: rtl/regfile_bypass_sb_pkg.sv
// Purpose: shared types, default sizes and port-bus slicing helper for the register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_bypass_sb_pkg;

  localparam int RF_W  = 32;
  localparam int RF_N  = 5;
  localparam int RF_NR = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  // Base bit offset of a port's field inside a packed per-port bus.
  function automatic int rf_idx(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_bypass_sb_if.sv
// Purpose: read/write/scoreboard bundle between the issue stage (master) and the file (slave).
// Latency: n/a (wiring only).
// Backpressure: ready low while the post-reset clear runs; writes and allocs are ignored then.
// Signals: raddr/rdata/rbusy are NR packed ports; we/rd/data_in write port;
//          alloc_en/alloc_rd scoreboard allocation; ready = clear complete.
interface regfile_bypass_sb_if
  import regfile_bypass_sb_pkg::*;
#(
  parameter int W  = RF_W,
  parameter int N  = RF_N,
  parameter int NR = RF_NR
) ();

  logic [NR*N-1:0] raddr;
  logic [NR*W-1:0] rdata;
  logic [NR-1:0]   rbusy;
  logic            we;
  logic [N-1:0]    rd;
  logic [W-1:0]    data_in;
  logic            alloc_en;
  logic [N-1:0]    alloc_rd;
  logic            ready;

  modport master (
    output raddr, we, rd, data_in, alloc_en, alloc_rd,
    input  rdata, rbusy, ready
  );

  modport slave (
    input  raddr, we, rd, data_in, alloc_en, alloc_rd,
    output rdata, rbusy, ready
  );

endinterface

// File: rtl/regfile_bypass_sb_clear_seq.sv
// Purpose: post-reset sweep that zeroes entries 1..2**N-1 one per cycle, then enters RUN.
// Latency: 2**N-1 cycles of CLEAR after rst drops; o_ready high from the first RUN cycle.
// Backpressure: none; o_ready low tells the file to ignore writes/allocs during the sweep.
// Ports: clk, rst (sync, active-high); o_clr_we/o_clr_addr drive the array write port
//        during CLEAR; o_ready = sweep finished.
module regfile_bypass_sb_clear_seq
  import regfile_bypass_sb_pkg::*;
#(
  parameter int N = RF_N
) (
  input  logic         clk,
  input  logic         rst,
  output logic         o_clr_we,
  output logic [N-1:0] o_clr_addr,
  output logic         o_ready
);

  localparam logic [N-1:0] LAST_ADDR = '1;
  localparam logic [N-1:0] FIRST_ADDR = N'(1);

  rf_state_t    r_state;
  rf_state_t    w_state_nxt;
  logic [N-1:0] r_cnt;
  logic [N-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= FIRST_ADDR;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_clr_we    = 1'b0;
    o_clr_addr  = r_cnt;
    o_ready     = 1'b0;
    unique case (r_state)
      CLEAR: begin
        // Entry 0 is never stored; reads of address 0 are forced to zero.
        o_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        o_ready = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Purpose: NR-read/1-write register file with write->read bypass and pending scoreboard.
// Latency: reads combinational; writes land in the array at the next edge, bypassed same cycle.
// Backpressure: ready low during the post-reset clear; we/alloc_en ignored, outputs forced 0.
// Ports: clk, rst (sync, active-high); rf = slave side of regfile_bypass_sb_if
//        (raddr/rdata/rbusy per port, we/rd/data_in, alloc_en/alloc_rd, ready).
module regfile_bypass_sb
  import regfile_bypass_sb_pkg::*;
#(
  parameter int W      = RF_W,
  parameter int N      = RF_N,
  parameter int NR     = RF_NR,
  parameter bit BYPASS = 1'b1
) (
  input logic                clk,
  input logic                rst,
  regfile_bypass_sb_if.slave rf
);

  localparam int DEPTH = 2 ** N;

  logic         w_clr_we;
  logic [N-1:0] w_clr_addr;
  logic         w_ready;

  regfile_bypass_sb_clear_seq #(.N(N)) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_ready    (w_ready)
  );

  // Array has no reset so it still maps onto RAM; the sweep does the zeroing.
  logic [W-1:0] r_mem [DEPTH];
  logic         w_run_we;
  logic         w_arr_we;
  logic [N-1:0] w_arr_addr;
  logic [W-1:0] w_arr_dat;

  assign w_run_we = w_ready && rf.we && (rf.rd != '0);

  always_comb begin
    w_arr_we   = 1'b0;
    w_arr_addr = w_clr_addr;
    w_arr_dat  = '0;
    if (!rst) begin
      if (w_ready) begin
        w_arr_we   = w_run_we;
        w_arr_addr = rf.rd;
        w_arr_dat  = rf.data_in;
      end else begin
        w_arr_we   = w_clr_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_arr_we) begin
      r_mem[w_arr_addr] <= w_arr_dat;
    end
  end

  // Scoreboard: the write clears first, then alloc sets, so a same-cycle
  // alloc+write to one register leaves it pending for the new producer.
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_ready) begin
      if (w_run_we) begin
        w_pend_nxt[rf.rd] = 1'b0;
      end
      if (rf.alloc_en) begin
        w_pend_nxt[rf.alloc_rd] = 1'b1;
      end
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    logic [N-1:0] w_ra;
    logic         w_hit;
    logic         w_zero;

    assign w_ra   = rf.raddr[rf_idx(gi, N) +: N];
    // A matching write this cycle supplies the value, so the reader is not stalled.
    assign w_hit  = BYPASS && rf.we && (rf.rd == w_ra);
    assign w_zero = !w_ready || (w_ra == '0);

    assign rf.rdata[rf_idx(gi, W) +: W] = w_zero ? '0 :
                                          (w_hit ? rf.data_in : r_mem[w_ra]);
    assign rf.rbusy[gi] = !w_zero && !w_hit && r_pend[w_ra];
  end

  assign rf.ready = w_ready;

endmodule
